pipe_ctrl_n: RTL and testbench

//  Parametrised N-stage in-order pipeline controller; successor to the fixed 5-stage stall/flush chain.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_n_if.sv | 31 +++
 rtl/pipe_perf_cnt.sv | 32 +++
 rtl/pipe_ctrl_n.sv | 98 +++++++++
 tb/tb_pipe_ctrl_n.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stage-index type and canonical stage names for the
// in-order pipeline controller (names match the classic 5-stage layout).
package pipe_ctrl_pkg;

   localparam int unsigned MAX_STAGES = 16;
   localparam int unsigned STG_IDX_W  = $clog2(MAX_STAGES);

   typedef logic [STG_IDX_W-1:0] stg_idx_t;

   // Stage positions for STAGES=5; index 0 is the youngest (fetch).
   typedef enum stg_idx_t {
      STG_IF  = stg_idx_t'(0),
      STG_ID  = stg_idx_t'(1),
      STG_EX  = stg_idx_t'(2),
      STG_MEM = stg_idx_t'(3),
      STG_WB  = stg_idx_t'(4)
   } stg_name_e;

endpackage

// File: rtl/pipe_ctrl_n_if.sv
// pipe_ctrl_n_if: per-stage handshake bundle between the pipeline datapath
// (master) and the stall/flush controller (slave).
interface pipe_ctrl_n_if #(
   parameter int unsigned STAGES = 5
);

   localparam int unsigned SRC_W = $clog2(STAGES);

   logic              fetch_valid;
   logic [STAGES-1:0] stage_ready;
   logic [STAGES-1:0] flush_req;
   logic [STAGES-1:0] stage_valid;
   logic [STAGES-1:0] stage_stall;
   logic [STAGES-1:0] stage_flush;
   logic              redirect_valid;
   logic [SRC_W-1:0]  redirect_src;
   logic              retire;

   modport master (
      output fetch_valid, stage_ready, flush_req,
      input  stage_valid, stage_stall, stage_flush,
      input  redirect_valid, redirect_src, retire
   );

   modport slave (
      input  fetch_valid, stage_ready, flush_req,
      output stage_valid, stage_stall, stage_flush,
      output redirect_valid, redirect_src, retire
   );

endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: free-running wrap-around performance counters for the
// pipeline controller; only instantiated when PIPE_PERF_EN is defined.
module pipe_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             retire,
   input  logic             stall_any,
   input  logic             flush_taken,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_retired,
   output logic [CNT_W-1:0] perf_stalls,
   output logic [CNT_W-1:0] perf_flushes
);

   // Count cycles out of reset and qualifying events; counters wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles  <= '0;
         perf_retired <= '0;
         perf_stalls  <= '0;
         perf_flushes <= '0;
      end else begin
         perf_cycles <= perf_cycles + CNT_W'(1);
         if (retire)      perf_retired <= perf_retired + CNT_W'(1);
         if (stall_any)   perf_stalls  <= perf_stalls  + CNT_W'(1);
         if (flush_taken) perf_flushes <= perf_flushes + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: N-stage in-order pipeline stall/flush controller with bubble
// collapsing and oldest-wins flush arbitration.
// Optional feature macro: PIPE_PERF_EN (adds CNT_W and four perf counters).
module pipe_ctrl_n
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned STAGES = 5
`ifdef PIPE_PERF_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_n_if.slave ctl
`ifdef PIPE_PERF_EN
   , output logic [CNT_W-1:0] perf_cycles
   , output logic [CNT_W-1:0] perf_retired
   , output logic [CNT_W-1:0] perf_stalls
   , output logic [CNT_W-1:0] perf_flushes
`endif
);

   localparam int unsigned SRC_W = $clog2(STAGES);

   logic [STAGES-1:1] occ_q;
   logic [STAGES-1:0] occ;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] hit;
   logic [STAGES-1:0] flush_below;
   logic              take;
   logic [SRC_W-1:0]  k_idx;

   // Fetch occupancy is masked during reset so stall/flush outputs drop with occ_q.
   assign occ = {occ_q, ctl.fetch_valid & rst};
   assign hit = ctl.flush_req & occ;

   // Advance chain resolves oldest first; flush_below[j] is set when any older stage flushes.
   assign adv[STAGES-1]         = !occ[STAGES-1] | ctl.stage_ready[STAGES-1];
   assign flush_below[STAGES-1] = 1'b0;
   for (genvar i = 0; i < STAGES-1; i++) begin : g_chain
      assign adv[i]         = !occ[i] | (ctl.stage_ready[i] & adv[i+1]);
      assign flush_below[i] = flush_below[i+1] | hit[i+1];
   end

   // Priority encoder: the highest-index (oldest) valid requester wins.
   always_comb begin
      take  = |hit;
      k_idx = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         if (hit[i]) k_idx = SRC_W'(i);
      end
   end

   assign ctl.stage_valid = {occ_q, ctl.fetch_valid};
   assign ctl.stage_stall = occ & ~adv;
   assign ctl.stage_flush = flush_below;
   assign ctl.retire      = occ[STAGES-1] & ctl.stage_ready[STAGES-1];

   // Per-stage valid update: flush clears, advance loads from the younger stage, else hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q <= '0;
      end else begin
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (flush_below[i])
               occ_q[i] <= 1'b0;
            else if (adv[i])
               occ_q[i] <= occ[i-1] & adv[i-1] & !flush_below[i-1];
         end
      end
   end

   // Registered redirect pulse and the index of the stage that caused it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctl.redirect_valid <= 1'b0;
         ctl.redirect_src   <= '0;
      end else begin
         ctl.redirect_valid <= take;
         if (take) ctl.redirect_src <= k_idx;
      end
   end

`ifdef PIPE_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk          (clk),
      .rst          (rst),
      .retire       (ctl.retire),
      .stall_any    (|ctl.stage_stall),
      .flush_taken  (take),
      .perf_cycles  (perf_cycles),
      .perf_retired (perf_retired),
      .perf_stalls  (perf_stalls),
      .perf_flushes (perf_flushes)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb_pipe_ctrl_n: directed stimulus for pipe_ctrl_n (STAGES=5) with an
// instruction-movement model checked every cycle plus literal expectations.
module tb_pipe_ctrl_n;

   localparam int S = 5;
`ifdef PIPE_PERF_EN
   localparam int PW = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_n_if #(.STAGES(S)) bus ();

`ifdef PIPE_PERF_EN
   logic [PW-1:0] perf_cycles, perf_retired, perf_stalls, perf_flushes;
`endif

   pipe_ctrl_n #(
      .STAGES(S)
`ifdef PIPE_PERF_EN
      , .CNT_W(PW)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .ctl (bus)
`ifdef PIPE_PERF_EN
      , .perf_cycles  (perf_cycles)
      , .perf_retired (perf_retired)
      , .perf_stalls  (perf_stalls)
      , .perf_flushes (perf_flushes)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // An instruction in stage i moves on if, walking toward writeback, a hole
   // or the retiring end is reached before any valid stage that is not ready.
   function automatic bit moves(input logic [S-1:0] o, input logic [S-1:0] r, input int i);
      for (int j = i; j < S; j++) begin
         if (!o[j]) return 1'b1;
         if (!r[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   logic [S-1:1] m_occ = '0;
   logic [S-1:1] n_occ = '0;
   logic         m_rv = 1'b0, n_rv = 1'b0;
   logic [2:0]   m_rs = '0,   n_rs = '0;
`ifdef PIPE_PERF_EN
   logic [PW-1:0] mp_cyc = '0, mp_ret = '0, mp_stl = '0, mp_fl = '0;
   logic          n_ret = 1'b0, n_stl = 1'b0, n_fl = 1'b0;
`endif

   // Compare process: derive expected outputs from the model state and current inputs.
   always @(negedge clk) begin
      logic [S-1:0] o, mv, fl;
      int k;
      o = {m_occ, bus.fetch_valid & rst};
      k = -1;
      for (int i = S-1; i >= 0; i--)
         if (k < 0 && bus.flush_req[i] && o[i]) k = i;
      for (int i = 0; i < S; i++) begin
         mv[i] = moves(o, bus.stage_ready, i);
         fl[i] = (i < k);
      end
      check("m_valid",  32'(bus.stage_valid), 32'({m_occ, bus.fetch_valid}));
      check("m_stall",  32'(bus.stage_stall), 32'(o & ~mv));
      check("m_flush",  32'(bus.stage_flush), 32'(fl));
      check("m_retire", 32'(bus.retire), 32'(o[S-1] & bus.stage_ready[S-1]));
      check("m_redir_v",   32'(bus.redirect_valid), 32'(m_rv));
      check("m_redir_src", 32'(bus.redirect_src), 32'(m_rs));
`ifdef PIPE_PERF_EN
      check("m_perf_cyc", 32'(perf_cycles),  32'(mp_cyc));
      check("m_perf_ret", 32'(perf_retired), 32'(mp_ret));
      check("m_perf_stl", 32'(perf_stalls),  32'(mp_stl));
      check("m_perf_fl",  32'(perf_flushes), 32'(mp_fl));
      n_ret = o[S-1] & bus.stage_ready[S-1];
      n_stl = |(o & ~mv);
      n_fl  = (k >= 0);
`endif
      // A stage keeps its own instruction if it is stuck, or receives the younger one if that moves.
      for (int i = 1; i < S; i++)
         n_occ[i] = (o[i-1] & mv[i-1] & !fl[i-1]) | (o[i] & !mv[i] & !fl[i]);
      n_rv = (k >= 0);
      n_rs = (k >= 0) ? 3'(k) : m_rs;
   end

   // Model state advances on the clock and clears immediately on reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_occ <= '0;
         m_rv  <= 1'b0;
         m_rs  <= '0;
`ifdef PIPE_PERF_EN
         mp_cyc <= '0; mp_ret <= '0; mp_stl <= '0; mp_fl <= '0;
`endif
      end else begin
         m_occ <= n_occ;
         m_rv  <= n_rv;
         m_rs  <= n_rs;
`ifdef PIPE_PERF_EN
         mp_cyc <= mp_cyc + 1'b1;
         mp_ret <= mp_ret + PW'(n_ret);
         mp_stl <= mp_stl + PW'(n_stl);
         mp_fl  <= mp_fl  + PW'(n_fl);
`endif
      end
   end

   // One clock edge, then this cycle's inputs; returns mid-cycle for literal checks.
   task automatic step(input logic fv, input logic [S-1:0] rdy, input logic [S-1:0] fr);
      @(posedge clk);
      #1;
      bus.fetch_valid = fv;
      bus.stage_ready = rdy;
      bus.flush_req   = fr;
      #3;
   endtask

   typedef struct { logic fv; logic [S-1:0] rdy; logic [S-1:0] fr; } vec_t;
   vec_t vecs[10] = '{
      '{1'b1, 5'b11111, 5'b00000}, '{1'b1, 5'b01111, 5'b00000},
      '{1'b1, 5'b01111, 5'b10000}, '{1'b0, 5'b11111, 5'b00001},
      '{1'b1, 5'b11101, 5'b00000}, '{1'b1, 5'b11111, 5'b00010},
      '{1'b1, 5'b10101, 5'b00000}, '{1'b0, 5'b11111, 5'b11000},
      '{1'b1, 5'b11110, 5'b00000}, '{1'b1, 5'b11111, 5'b00000}
   };

   initial begin
      bus.fetch_valid = 1'b0;
      bus.stage_ready = '1;
      bus.flush_req   = '0;
      repeat (2) @(posedge clk);
      #4;
      check("rst_valid", 32'(bus.stage_valid), 32'h0);

      // Fill: all ready, continuous fetch.
      @(posedge clk); #1;
      rst = 1'b1;
      bus.fetch_valid = 1'b1;
      #3;
      check("fill0_valid",  32'(bus.stage_valid), 32'b00001);
      check("fill0_retire", 32'(bus.retire), 32'h0);
      for (int n = 0; n < 4; n++) begin
         step(1'b1, 5'b11111, 5'b00000);
         check("fill_valid", 32'(bus.stage_valid), (32'd1 << (n + 2)) - 32'd1);
      end
      check("full_retire", 32'(bus.retire), 32'h1);
      check("full_stall",  32'(bus.stage_stall), 32'h0);
      check("full_flush",  32'(bus.stage_flush), 32'h0);

      // Stage 3 not ready for three cycles.
      step(1'b1, 5'b10111, 5'b00000);
      check("s3_stall_a",  32'(bus.stage_stall), 32'b01111);
      check("s3_retire_a", 32'(bus.retire), 32'h1);
      step(1'b1, 5'b10111, 5'b00000);
      check("s3_valid_b",  32'(bus.stage_valid), 32'b01111);
      check("s3_retire_b", 32'(bus.retire), 32'h0);
      step(1'b1, 5'b10111, 5'b00000);
      check("s3_stall_c",  32'(bus.stage_stall), 32'b01111);
      check("s3_retire_c", 32'(bus.retire), 32'h0);
      step(1'b1, 5'b11111, 5'b00000);
      check("s3_stall_d",  32'(bus.stage_stall), 32'h0);
      check("s3_retire_d", 32'(bus.retire), 32'h0);

      // Bubble squeeze: build 10101 and stall stage 2.
      step(1'b1, 5'b11111, 5'b00000);
      step(1'b0, 5'b11111, 5'b00000);
      step(1'b1, 5'b11111, 5'b00000);
      step(1'b0, 5'b11111, 5'b00000);
      step(1'b1, 5'b11011, 5'b00000);
      check("bub_valid",  32'(bus.stage_valid), 32'b10101);
      check("bub_stall",  32'(bus.stage_stall), 32'b00100);
      check("bub_retire", 32'(bus.retire), 32'h1);
      step(1'b1, 5'b11011, 5'b00000);
      check("bub2_valid", 32'(bus.stage_valid), 32'b00111);
      check("bub2_stall", 32'(bus.stage_stall), 32'b00111);

      // Two simultaneous flush requesters: oldest (3) wins.
      repeat (5) step(1'b1, 5'b11111, 5'b00000);
      check("pre_fl_valid", 32'(bus.stage_valid), 32'b11111);
      step(1'b1, 5'b11111, 5'b01100);
      check("fl_flush", 32'(bus.stage_flush), 32'b00111);
      check("fl_stall", 32'(bus.stage_stall), 32'h0);
      step(1'b1, 5'b11111, 5'b00000);
      check("fl_valid",   32'(bus.stage_valid), 32'b10001);
      check("fl_redir_v", 32'(bus.redirect_valid), 32'h1);
      check("fl_redir_s", 32'(bus.redirect_src), 32'd3);

      // Flush request from an empty stage is ignored.
      step(1'b1, 5'b11111, 5'b00100);
      check("inv_valid", 32'(bus.stage_valid), 32'b00011);
      check("inv_flush", 32'(bus.stage_flush), 32'h0);
      step(1'b1, 5'b11111, 5'b00000);
      check("inv_redir_v", 32'(bus.redirect_valid), 32'h0);
      check("inv_redir_s", 32'(bus.redirect_src), 32'd3);

      // Reset mid-stream with hostile inputs.
      repeat (3) step(1'b1, 5'b11111, 5'b00000);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.fetch_valid = 1'b1;
      bus.stage_ready = 5'b11110;
      bus.flush_req   = 5'b11111;
      #2;
      check("mrst_valid",  32'(bus.stage_valid), 32'b00001);
      check("mrst_stall",  32'(bus.stage_stall), 32'h0);
      check("mrst_flush",  32'(bus.stage_flush), 32'h0);
      check("mrst_retire", 32'(bus.retire), 32'h0);
      check("mrst_redir",  32'(bus.redirect_valid), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.stage_ready = '1;
      bus.flush_req   = '0;

      // Mixed vectors, checked by the model only.
      foreach (vecs[i]) step(vecs[i].fv, vecs[i].rdy, vecs[i].fr);
      repeat (3) step(1'b0, 5'b11111, 5'b00000);

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
